// File: rtl/jtpang_romarb.sv
// Two-requester arbiter sharing one 32-bit graphics ROM port, with a one-entry data cache per requester.
// Optional macro JTPANG_ROMARB_PRIO_EN: fixed priority for requester 0; otherwise round-robin.
module jtpang_romarb #(
    parameter int              AW0  = 17,
    parameter int              AW1  = 17,
    parameter int              AW   = 22,
    parameter logic [AW-1:0]   OFF0 = '0,
    parameter logic [AW-1:0]   OFF1 = 22'h20000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rq0_cs,
    input  logic [AW0-1:0]  rq0_addr,
    output logic            rq0_ok,
    output logic [31:0]     rq0_data,
    input  logic            rq1_cs,
    input  logic [AW1-1:0]  rq1_addr,
    output logic            rq1_ok,
    output logic [31:0]     rq1_data,
    output logic            rom_cs,
    output logic [AW-1:0]   rom_addr,
    input  logic            rom_ok,
    input  logic [31:0]     rom_data,
    output logic            owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_rom_cs;
    logic [AW-1:0]   r_rom_addr;
    logic            r_owner;

    logic [AW0-1:0]  r_tag0;
    logic [31:0]     r_data0;
    logic            r_valid0;
    logic [AW1-1:0]  r_tag1;
    logic [31:0]     r_data1;
    logic            r_valid1;

    logic            w_hit0;
    logic            w_hit1;
    logic            w_pend0;
    logic            w_pend1;
    logic            w_sel1;
    logic            w_issue;
    logic            w_fill;
    logic [AW-1:0]   w_addr0;
    logic [AW-1:0]   w_addr1;

    assign w_hit0  = rq0_cs & r_valid0 & (rq0_addr == r_tag0);
    assign w_hit1  = rq1_cs & r_valid1 & (rq1_addr == r_tag1);
    assign w_pend0 = rq0_cs & ~w_hit0;
    assign w_pend1 = rq1_cs & ~w_hit1;

    assign w_addr0 = {{(AW-AW0){1'b0}}, rq0_addr} + OFF0;
    assign w_addr1 = {{(AW-AW1){1'b0}}, rq1_addr} + OFF1;

`ifdef JTPANG_ROMARB_PRIO_EN
    assign w_sel1 = ~w_pend0;
`else
    // On contention the requester that was not served last goes first
    assign w_sel1 = w_pend1 & (~w_pend0 | ~r_owner);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_fill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend0 | w_pend1) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rom_ok) begin
                    w_fill      = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            // One dead cycle so a trailing rom_ok from the slot is never taken as data
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_cs   <= 1'b0;
            r_rom_addr <= '0;
            r_owner    <= 1'b0;
            r_tag0     <= '0;
            r_data0    <= '0;
            r_valid0   <= 1'b0;
            r_tag1     <= '0;
            r_data1    <= '0;
            r_valid1   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rom_cs <= 1'b1;
                r_owner  <= w_sel1;
                if (w_sel1) begin
                    r_rom_addr <= w_addr1;
                    r_tag1     <= rq1_addr;
                    r_valid1   <= 1'b0;
                end else begin
                    r_rom_addr <= w_addr0;
                    r_tag0     <= rq0_addr;
                    r_valid0   <= 1'b0;
                end
            end
            // Fill goes to the owner's tag even if its address or cs moved meanwhile
            if (w_fill) begin
                r_rom_cs <= 1'b0;
                if (r_owner) begin
                    r_data1  <= rom_data;
                    r_valid1 <= 1'b1;
                end else begin
                    r_data0  <= rom_data;
                    r_valid0 <= 1'b1;
                end
            end
        end
    end

    assign rq0_ok   = w_hit0;
    assign rq0_data = r_data0;
    assign rq1_ok   = w_hit1;
    assign rq1_data = r_data1;
    assign rom_cs   = r_rom_cs;
    assign rom_addr = r_rom_addr;
    assign owner    = r_owner;

endmodule

// File: tb/tb_jtpang_romarb.sv
// Bench for jtpang_romarb: directed scenarios then random traffic, checked every cycle against a transaction model.
module tb_jtpang_romarb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rq0_cs = 1'b0;
    logic [16:0]  rq0_addr = '0;
    logic         rq0_ok;
    logic [31:0]  rq0_data;
    logic         rq1_cs = 1'b0;
    logic [16:0]  rq1_addr = '0;
    logic         rq1_ok;
    logic [31:0]  rq1_data;
    logic         rom_cs;
    logic [21:0]  rom_addr;
    logic         rom_ok = 1'b0;
    logic [31:0]  rom_data = '0;
    logic         owner;

    always #5 clk = ~clk;

    jtpang_romarb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rq0_cs   (rq0_cs),
        .rq0_addr (rq0_addr),
        .rq0_ok   (rq0_ok),
        .rq0_data (rq0_data),
        .rq1_cs   (rq1_cs),
        .rq1_addr (rq1_addr),
        .rq1_ok   (rq1_ok),
        .rq1_data (rq1_data),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .owner    (owner)
    );

    int total = 0;
    int bad   = 0;

    // Model: one outstanding ROM transaction; waiting/gap phase tracked as plain flags
    logic         m_in_flight;
    logic         m_in_gap;
    logic [21:0]  m_addr;
    logic         m_owner;
    logic [16:0]  m_tag [2];
    logic         m_val [2];
    logic [31:0]  m_dat [2];

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_flight = 1'b0;
        m_in_gap    = 1'b0;
        m_addr      = '0;
        m_owner     = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_tag[n] = '0;
            m_val[n] = 1'b0;
            m_dat[n] = '0;
        end
    endtask

    function automatic logic m_hit(input int n);
        if (n == 0) return rq0_cs && m_val[0] && (rq0_addr == m_tag[0]);
        return rq1_cs && m_val[1] && (rq1_addr == m_tag[1]);
    endfunction

    task automatic model_step();
        logic p0, p1, win;
        if (!rst_n) begin
            model_reset();
            return;
        end
        p0 = rq0_cs && !m_hit(0);
        p1 = rq1_cs && !m_hit(1);
        if (m_in_gap) begin
            m_in_gap = 1'b0;
        end else if (m_in_flight) begin
            if (rom_ok) begin
                m_dat[m_owner] = rom_data;
                m_val[m_owner] = 1'b1;
                m_in_flight    = 1'b0;
                m_in_gap       = 1'b1;
            end
        end else if (p0 || p1) begin
`ifdef JTPANG_ROMARB_PRIO_EN
            win = !p0;
`else
            win = (p0 && p1) ? !m_owner : p1;
`endif
            m_owner     = win;
            m_in_flight = 1'b1;
            m_val[win]  = 1'b0;
            if (win) begin
                m_tag[1] = rq1_addr;
                m_addr   = 22'h20000 + {5'd0, rq1_addr};
            end else begin
                m_tag[0] = rq0_addr;
                m_addr   = 22'h0 + {5'd0, rq0_addr};
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            if (!rst_n) model_reset();
            chk("rq0_ok",   rq0_ok,   m_hit(0));
            chk("rq0_data", rq0_data, m_dat[0]);
            chk("rq1_ok",   rq1_ok,   m_hit(1));
            chk("rq1_data", rq1_data, m_dat[1]);
            chk("rom_cs",   rom_cs,   m_in_flight);
            chk("rom_addr", rom_addr, m_addr);
            chk("owner",    owner,    m_owner);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic pulse_ok(input logic [31:0] d);
        rom_ok   = 1'b1;
        rom_data = d;
        cyc(1);
        rom_ok   = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset held with a pending request
        rq0_cs   = 1'b1;
        rq0_addr = 17'h10;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        #1;
        chk("rst_rel_cs",   rom_cs,   32'd1);
        chk("rst_rel_addr", rom_addr, 32'h10);
        pulse_ok(32'h0BAD_F00D);
        cyc(2);

        // Single miss then hit
        rq0_addr = 17'h123;
        cyc(1);
        cyc(5);
        pulse_ok(32'hDEADBEEF);
        #1;
        chk("miss_ok",   rq0_ok,   32'd1);
        chk("miss_data", rq0_data, 32'hDEADBEEF);
        chk("gap_cs",    rom_cs,   32'd0);
        cyc(3);
        rq0_cs = 1'b0;
        cyc(1);
        rq0_cs = 1'b1;
        #1;
        chk("rehit_ok", rq0_ok, 32'd1);
        cyc(2);
        chk("rehit_cs", rom_cs, 32'd0);

        // Contention with last owner 0
        rq0_addr = 17'h55;
        rq1_cs   = 1'b1;
        rq1_addr = 17'h9;
        cyc(1);
`ifdef JTPANG_ROMARB_PRIO_EN
        chk("cont_first", rom_addr, 32'h55);
`else
        chk("cont_first", rom_addr, 32'h20009);
`endif
        cyc(2);
        pulse_ok(32'h1111_2222);
        cyc(2);
        pulse_ok(32'h3333_4444);
        cyc(2);

        // Address change during fetch
        rq0_cs   = 1'b0;
        rq1_addr = 17'h5;
        cyc(3);
        rq1_addr = 17'h6;
        cyc(1);
        pulse_ok(32'h5555_6666);
        chk("chg_ok_low", rq1_ok, 32'd0);
        cyc(2);
        chk("chg_reissue", rom_addr, 32'h20006);
        pulse_ok(32'h7777_8888);
        cyc(1);

        // Stale rom_ok in GAP and IDLE with both requesters hitting
        rq0_cs   = 1'b1;
        rq0_addr = 17'h55;
        rom_ok   = 1'b1;
        rom_data = 32'hFFFF_0000;
        cyc(4);
        rom_ok   = 1'b0;
        cyc(1);

        // Reset during a fetch
        rq0_addr = 17'h77;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("async_cs", rom_cs, 32'd0);
        chk("async_ok", rq1_ok, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        pulse_ok(32'hCAFE_0001);
        cyc(3);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rq0_cs = ($urandom_range(0, 3) != 0);
            rq1_cs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) rq0_addr = 17'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rq1_addr = 17'($urandom_range(0, 3));
            rom_ok   = ($urandom_range(0, 2) == 0);
            rom_data = $urandom;
            rst_n    = ($urandom_range(0, 199) != 0);
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtpang_romarb.md
Name: jtpang_romarb

Overview:
- Two-requester arbiter sharing one 32-bit graphics ROM (SDRAM) port in the Pang video path.
- Requester 0 is the object line drawer; requester 1 is the char/scroll tile fetcher.
- Each requester gets a one-entry data cache, so repeated reads of the same address complete without a new SDRAM access.
- Sits between the video engines and the framework SDRAM slot.

Parameters:
AW0, 17, requester 0 address width (32-bit words)
AW1, 17, requester 1 address width
AW, 22, downstream SDRAM address width; must be >= AW0+1 and >= AW1+1
OFF0, 22'h0, word offset added to requester 0 address
OFF1, 22'h20000, word offset added to requester 1 address

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rq0_cs  in  1  requester 0 read request, level
rq0_addr  in  AW0  requester 0 word address
rq0_ok  out  1  rq0_data valid for current rq0_addr
rq0_data  out  32  requester 0 read data
rq1_cs  in  1  requester 1 read request, level
rq1_addr  in  AW1  requester 1 word address
rq1_ok  out  1  rq1_data valid for current rq1_addr
rq1_data  out  32  requester 1 read data
rom_cs  out  1  SDRAM request
rom_addr  out  AW  SDRAM word address
rom_ok  in  1  SDRAM data valid
rom_data  in  32  SDRAM data
owner  out  1  requester currently served (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: rom_cs=0, rom_addr=0, owner=0. Both cache valid bits are 0, so rq0_ok=rq1_ok=0. Cache data and tags are 0. State is IDLE.
- Cache per requester n: tag_n (AWn bits), data_n (32 bits), valid_n.
  - hit_n = rqn_cs & valid_n & (rqn_addr==tag_n)
  - rqn_ok = hit_n, combinational
  - rqn_data = data_n
  - On a hit, latency is 0 cycles.
- pend_n = rqn_cs & ~hit_n.
- State machine:
  - IDLE: if any pend_n, select the winner, then set rom_cs<=1, rom_addr<=OFFn+rqn_addr (zero-extended, sum truncated to AW), latch tag_n<=rqn_addr, clear valid_n, set owner<=n, go to BUSY. If nothing is pending, stay in IDLE.
  - BUSY: hold rom_cs and rom_addr stable. When rom_ok=1: data_{owner}<=rom_data, valid_{owner}<=1, rom_cs<=0, go to GAP.
  - GAP: rom_cs stays 0 for exactly one cycle so a stale rom_ok is never sampled. Go to IDLE.
- Winner selection: round-robin. Requester 0 wins if only it is pending. Requester 1 wins if only it is pending. If both are pending, the requester that was not the last owner wins.
- Timing: a request first seen in IDLE at edge k drives rom_cs high after edge k. Data arriving with rom_ok at edge m sets rqn_ok after edge m, provided cs and addr are unchanged. A back-to-back miss then issues at the earliest at edge m+2.
- If rqn_cs drops mid-transaction: the access completes and the cache is filled anyway; rqn_ok stays 0 while cs is low.
- If rqn_addr changes mid-transaction: the access completes for the old address. The cache now misses, and the new address is requested in a later IDLE.
- rom_ok outside BUSY is ignored.
- Only the owner's cache is written. The other requester's cache and ok stay unaffected throughout.
- When rst_n asserts mid-transaction, state is cleared immediately and rom_cs falls asynchronously.

Optional Feature:
- Macro: JTPANG_ROMARB_PRIO_EN.
- Defined: fixed priority. Requester 0 (objects) wins whenever pend_0 is set in IDLE, and requester 1 is served only when pend_0=0.
- Undefined: round-robin as described above.
- Everything else is identical in both builds.

Test Plan:
- Reset state: hold rst_n=0 with rq0_cs=1 -> rom_cs=0, rq0_ok=0. Release rst_n -> rom_cs=1 one edge later, rom_addr=OFF0+rq0_addr.
- Single miss then hit: rq0_addr=17'h123, rom_ok pulsed with rom_data=32'hDEADBEEF after 5 cycles:
  - rq0_ok=1 and rq0_data=32'hDEADBEEF on the next cycle, and rom_cs low for exactly one cycle.
  - Re-asserting the same address gives rq0_ok=1 immediately with no new rom_cs.
- Contention: rq0 and rq1 miss together, last owner=0 -> requester 1 is served first (rom_addr=OFF1+rq1_addr), then requester 0. With JTPANG_ROMARB_PRIO_EN defined, requester 0 is served first.
- Address change mid-fetch: rq1_addr moves 5->6 while BUSY -> fill completes with tag 5 and rq1_ok stays 0. The next access issues rom_addr=OFF1+6 and rq1_ok rises after its rom_ok.
- Stale ok: inject rom_ok in GAP and IDLE -> no cache write, no rqn_ok change.
- Reset mid-fetch: pull rst_n low during BUSY -> rom_cs drops asynchronously and valid bits clear. After release, the pending request is reissued.
